// File: rtl/piso_shift_tx.sv
// rtl/piso_shift_tx.sv - parallel-in serial-out transmitter with load/ready handshake
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   in        parallel word, captured on load while ready
//   load      capture request, honoured only while ready=1
//   en        shift enable; 0 stalls the current bit on sout
//   ready     idle and able to accept a word
//   sout      serial data bit, 0 when valid_out=0
//   valid_out sout carries a word bit
//   done      one-cycle pulse in the first idle cycle after a word

module piso_shift_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             en,
    output logic             ready,
    output logic             sout,
    output logic             valid_out,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             done_q,  done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d = in;
                    cnt_d   = CW'(WIDTH);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (cnt_q == CW'(1)) begin
                        // Last bit leaves on this edge; clearing the register keeps
                        // sout at 0 in IDLE without extra gating.
                        state_d = IDLE;
                        shreg_d = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                        end else begin
                            shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
                        end
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign valid_out = (state_q == SHIFT);
    assign sout      = valid_out & (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0]);
    assign done      = done_q;

endmodule

// File: tb/tb_piso_shift_tx.sv
// tb/tb_piso_shift_tx.sv - randomized and directed bench for piso_shift_tx against a bit-queue model

module tb_piso_shift_tx;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         load;
    logic         en;

    logic ready_m, sout_m, valid_m, done_m;
    logic ready_l, sout_l, valid_l, done_l;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in(in), .load(load), .en(en),
        .ready(ready_m), .sout(sout_m), .valid_out(valid_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in(in), .load(load), .en(en),
        .ready(ready_l), .sout(sout_l), .valid_out(valid_l), .done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_bad;

    // Model: index 0 = MSB-first instance, 1 = LSB-first instance.
    // A word is the queue of bits still to be sent; empty queue means idle.
    bit   mq[2][$];
    logic md[2];

    logic [31:0] seq_m;
    logic [31:0] seq_l;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic nd;
            nd = 1'b0;
            if (rst) begin
                mq[k].delete();
            end else if (mq[k].size() == 0) begin
                if (load) begin
                    for (int b = 0; b < W; b++) begin
                        mq[k].push_back(k == 0 ? in[W-1-b] : in[b]);
                    end
                end
            end else if (en) begin
                void'(mq[k].pop_front());
                if (mq[k].size() == 0) nd = 1'b1;
            end
            md[k] = nd;
        end
    endtask

    task automatic check_outputs();
        logic [3:0] obs[2];
        logic [3:0] exp;
        obs[0] = {ready_m, valid_m, sout_m, done_m};
        obs[1] = {ready_l, valid_l, sout_l, done_l};
        for (int k = 0; k < 2; k++) begin
            exp[3] = (mq[k].size() == 0);
            exp[2] = (mq[k].size() != 0);
            exp[1] = (mq[k].size() != 0) ? mq[k][0] : 1'b0;
            exp[0] = md[k];
            chk($sformatf("ready[%0d]", k), 32'(obs[k][3]), 32'(exp[3]));
            chk($sformatf("valid_out[%0d]", k), 32'(obs[k][2]), 32'(exp[2]));
            chk($sformatf("sout[%0d]", k), 32'(obs[k][1]), 32'(exp[1]));
            chk($sformatf("done[%0d]", k), 32'(obs[k][0]), 32'(exp[0]));
        end
    endtask

    // Inputs are set well after the edge; the model consumes them just before it.
    task automatic tick();
        if (!rst && en) begin
            if (valid_m) seq_m = {seq_m[30:0], sout_m};
            if (valid_l) seq_l = {seq_l[30:0], sout_l};
        end
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        md[0] = 1'b0;
        md[1] = 1'b0;
        rst   = 1'b1;
        in    = '0;
        load  = 1'b0;
        en    = 1'b1;
        seq_m = '0;
        seq_l = '0;

        // Reset with a concurrent load that must be discarded.
        load = 1'b1;
        in   = 4'b1111;
        ticks(2);
        load = 1'b0;
        rst  = 1'b0;
        chk("reset_ready", 32'(ready_m), 32'd1);
        chk("reset_sout", 32'(sout_m), 32'd0);

        // Basic transfer, both bit orders.
        seq_m = '0; seq_l = '0;
        in = 4'b1001; load = 1'b1; tick();
        load = 1'b0;
        chk("s1_busy", 32'(ready_m), 32'd0);
        ticks(4);
        chk("s1_done", 32'(done_m), 32'd1);
        chk("s1_stream_msb", seq_m, 32'b1001);
        chk("s1_stream_lsb", seq_l, 32'b1001);
        tick();

        seq_m = '0; seq_l = '0;
        in = 4'b1011; load = 1'b1; tick();
        load = 1'b0;
        ticks(5);
        chk("s2_stream_msb", seq_m, 32'b1011);
        chk("s2_stream_lsb", seq_l, 32'b1101);

        // Stall after the first bit.
        seq_m = '0; seq_l = '0;
        in = 4'b1100; load = 1'b1; tick();
        load = 1'b0;
        tick();
        en = 1'b0;
        ticks(3);
        chk("stall_sout", 32'(sout_m), 32'd1);
        chk("stall_valid", 32'(valid_m), 32'd1);
        en = 1'b1;
        ticks(4);
        chk("stall_stream_msb", seq_m, 32'b1100);
        chk("stall_stream_lsb", seq_l, 32'b0011);

        // Load pulses while busy, including on the final-shift edge.
        seq_m = '0; seq_l = '0;
        in = 4'b1010; load = 1'b1; tick();
        load = 1'b0; tick();
        in = 4'b0110; load = 1'b1; tick();
        load = 1'b0; tick();
        load = 1'b1; tick();
        load = 1'b0;
        chk("busy_done", 32'(done_m), 32'd1);
        ticks(3);
        chk("busy_idle", 32'(ready_m), 32'd1);
        chk("busy_stream_msb", seq_m, 32'b1010);

        // Reset mid-transfer with a simultaneous load.
        in = 4'b1111; load = 1'b1; tick();
        load = 1'b0; ticks(2);
        rst = 1'b1; load = 1'b1; in = 4'b1010; tick();
        rst = 1'b0; load = 1'b0;
        chk("abort_ready", 32'(ready_m), 32'd1);
        chk("abort_done", 32'(done_m), 32'd0);
        ticks(3);

        // Back-to-back words with load held high.
        seq_m = '0; seq_l = '0;
        in = 4'b0011; load = 1'b1; tick();
        in = 4'b0101;
        ticks(8);
        load = 1'b0;
        ticks(2);
        chk("b2b_stream_msb", seq_m, 32'b0011_0101);
        chk("b2b_stream_lsb", seq_l, 32'b1100_1010);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            in   = W'($urandom);
            load = ($urandom_range(0, 3) == 0);
            en   = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 49) == 0);
            tick();
        end
        rst = 1'b0; load = 1'b0; en = 1'b1;
        ticks(W + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
